// File: rtl/md_unit_pkg.sv
// Shared opcodes and FSM encoding for the iterative multiply/divide unit.
package md_unit_pkg;

  localparam logic [2:0] MD_op_mult  = 3'd0;
  localparam logic [2:0] MD_op_multu = 3'd1;
  localparam logic [2:0] MD_op_div   = 3'd2;
  localparam logic [2:0] MD_op_divu  = 3'd3;
  localparam logic [2:0] MD_op_mthi  = 3'd4;
  localparam logic [2:0] MD_op_mtlo  = 3'd5;

  typedef enum logic [1:0] {
    MD_st_idle = 2'd0,
    MD_st_calc = 2'd1,
    MD_st_fix  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit_negate.sv
// Conditional two's-complement: used for operand magnitudes and result sign fix-up.
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] dOut
);

  assign dOut = neg ? (~dIn + WIDTH'(1)) : dIn;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding HI/LO: radix-2 shift-add multiply,
// restoring divide on magnitudes, sign fix-up in a final FIX cycle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] dInA,
  input  logic [WIDTH-1:0] dInB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: start is taken only on an edge where busy=0 and flush=0; while
  // busy=1 the pipeline must stall, and any start is dropped, never queued.
  localparam int W2 = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d, a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, div0_q, div0_d;
  logic             sgn_res_q, sgn_res_d, sgn_rem_q, sgn_rem_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             signed_op, md_op, op_div;
  logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix, trial;
  logic [W2-1:0]    prod_fix, mul_next, div_next;
  logic [WIDTH:0]   add_sum;
  logic             trial_ge;

  assign signed_op = (op == MD_op_mult) || (op == MD_op_div);
  assign op_div    = (op == MD_op_div) || (op == MD_op_divu);
  assign md_op     = (op == MD_op_mult) || (op == MD_op_multu) || op_div;

  md_negate #(.WIDTH(WIDTH)) u_mag_a (.neg(signed_op & dInA[WIDTH-1]), .dIn(dInA), .dOut(mag_a));
  md_negate #(.WIDTH(WIDTH)) u_mag_b (.neg(signed_op & dInB[WIDTH-1]), .dIn(dInB), .dOut(mag_b));
  md_negate #(.WIDTH(W2))    u_fix_prod (.neg(sgn_res_q), .dIn(acc_q), .dOut(prod_fix));
  md_negate #(.WIDTH(WIDTH)) u_fix_quo (.neg(sgn_res_q), .dIn(acc_q[WIDTH-1:0]), .dOut(quo_fix));
  md_negate #(.WIDTH(WIDTH)) u_fix_rem (.neg(sgn_rem_q), .dIn(acc_q[W2-1:WIDTH]), .dOut(rem_fix));

  // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    add_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q};
    mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
    trial_ge = acc_q[W2-1:WIDTH-1] >= {1'b0, b_q};
    trial    = acc_q[W2-2:WIDTH-1] - b_q;
    div_next = trial_ge ? {trial, acc_q[WIDTH-2:0], 1'b1} : {acc_q[W2-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    sgn_res_d = sgn_res_q;
    sgn_rem_d = sgn_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      MD_st_idle: begin
        if (start && !flush) begin
          if (md_op) begin
            state_d   = MD_st_calc;
            cnt_d     = '0;
            is_div_d  = op_div;
            a_raw_d   = dInA;
            div0_d    = (dInB == '0);
            sgn_res_d = signed_op & (dInA[WIDTH-1] ^ dInB[WIDTH-1]);
            sgn_rem_d = signed_op & dInA[WIDTH-1];
            acc_d     = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            b_d       = op_div ? mag_b : mag_a;
          end else if (op == MD_op_mthi) begin
            hi_d = dInA;
          end else if (op == MD_op_mtlo) begin
            lo_d = dInA;
          end
        end
      end
      MD_st_calc: begin
        if (flush) begin
          state_d = MD_st_idle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_st_fix;
        end
      end
      MD_st_fix: begin
        state_d = MD_st_idle;
        if (!flush) begin
          done_d = 1'b1;
          // Divide by zero bypasses the datapath: quotient all ones, dividend untouched.
          if (is_div_q && div0_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = MD_st_idle;
    endcase
    busy_d = (state_d != MD_st_idle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_st_idle;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      sgn_res_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      sgn_res_q <= sgn_res_d;
      sgn_rem_q <= sgn_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases, random ops against
// a 64-bit arithmetic reference, flush/ignore/reset behaviour.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] dInA, dInB;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   mdl_hi, mdl_lo;

  md_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .dInA(dInA), .dInB(dInB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width arithmetic with MIPS-style divide-by-zero result.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MD_op_mult:  return sa * sb;
      MD_op_multu: return ua * ub;
      MD_op_div: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_v, input bit poke);
    int cyc;
    logic [63:0] e;
    exp_q.push_back(exp_v);
    start = 1'b1; op = o; dInA = a; dInB = b;
    tick();
    start = 1'b0; dInA = $urandom; dInB = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 16) check({tag, "_mid_hilo"}, {hi, lo}, {mdl_hi, mdl_lo});
      if (poke && cyc == 5) begin
        start = 1'b1; op = MD_op_divu; dInA = $urandom; dInB = $urandom_range(1, 9);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, 64'(done), 64'd1);
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
    {mdl_hi, mdl_lo} = e;
    tick();
    check({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; dInA = '0; dInB = '0;
    mdl_hi = '0; mdl_lo = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    do_op("mult_7_m3",    MD_op_mult,  32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    do_op("multu_max",    MD_op_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    do_op("mult_m1_m1",   MD_op_mult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    do_op("div_m7_2",     MD_op_div,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_op("divu_7_2",     MD_op_divu,  32'd7,         32'd2,         64'h0000_0001_0000_0003, 1'b0);
    do_op("div_7_m2",     MD_op_div,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    do_op("divu_5_0",     MD_op_divu,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b0);
    do_op("div_m5_0",     MD_op_div,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    do_op("div_ovf",      MD_op_div,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    do_op("multu_poke",   MD_op_multu, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);

    // MTHI writes immediately without going busy.
    start = 1'b1; op = MD_op_mthi; dInA = 32'h1234;
    tick();
    start = 1'b0;
    mdl_hi = 32'h1234;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", {62'd0, busy, done}, 64'd0);

    // Flush at busy cycle 10 abandons the multiply.
    start = 1'b1; op = MD_op_multu; dInA = 32'd3; dInB = 32'd4;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_done", {62'd0, busy, done}, 64'd0);
    check("flush_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    repeat (40) tick();
    check("flush_no_late_done", {62'd0, busy, done}, 64'd0);
    check("flush_hilo_late", {hi, lo}, {mdl_hi, mdl_lo});

    // Undefined opcode is ignored.
    start = 1'b1; op = 3'd6; dInA = $urandom; dInB = $urandom;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("undef_busy", {62'd0, busy, done}, 64'd0);
    check("undef_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'hFFFF_FFFF;
        2:       r_b = 32'($urandom_range(1, 15));
        default: r_b = 32'($urandom);
      endcase
      do_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, model(r_op, r_a, r_b), i[0]);
    end

    // Reset mid-operation clears everything.
    start = 1'b1; op = MD_op_multu; dInA = $urandom; dInB = $urandom;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    check("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);

    start = 1'b1; op = MD_op_mtlo; dInA = 32'hABCD;
    tick();
    start = 1'b0;
    mdl_lo = 32'hABCD;
    check("mtlo_lo", {hi, lo}, {mdl_hi, mdl_lo});

    // start and flush together: flush wins.
    start = 1'b1; flush = 1'b1; op = MD_op_mult; dInA = 32'd3; dInB = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    repeat (40) tick();
    check("start_flush_done", {62'd0, busy, done}, 64'd0);
    check("start_flush_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit that sits beside the EX-stage ALU of the MIPS pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- Parametrised in data width. Uses a radix-2 shift-add multiplier and a restoring divider with sign fix-up.
- Hazard logic stalls MFHI/MFLO, and any new MD op, while busy is high.

Parameters:
- WIDTH, 32: operand/HI/LO width. Must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation code; MD_op_* constants.
- flush  input  1  abort the in-flight op (exception/branch squash).
- dInA  input  WIDTH  R[rs]: multiplicand / dividend / MTHI-MTLO data.
- dInB  input  WIDTH  R[rt]: multiplier / divisor.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse when HI/LO take a mult/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at an edge): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides start and flush, including mid-operation.
- States:
  - IDLE -> CALC on start with op in {mult, multu, div, divu}.
  - CALC: exactly WIDTH iterations, then -> FIX.
  - FIX: one cycle, then -> IDLE.
- Latency: start sampled at edge k. busy=1 after edges k+1 .. k+WIDTH+1, i.e. WIDTH+1 cycles. hi/lo load at edge k+WIDTH+1; busy falls and done=1 in the same cycle; done lasts one cycle.
- Operand capture: dInA/dInB are latched at the start edge. Later input changes have no effect.
- Signed ops (mult, div): operands converted to magnitudes at capture. Signs are recorded:
  - product sign = sA xor sB;
  - quotient sign = sA xor sB;
  - remainder sign = sA.
- FIX applies conditional negation to the raw result.
- mult/multu result: {hi,lo} = full 2*WIDTH-bit product.
- div/divu result: lo = quotient, hi = remainder. Truncation toward zero.
- Divide by zero (signed or unsigned): lo = all ones, hi = dInA unchanged. Same latency.
- Signed overflow (MIN / -1): lo = MIN, hi = 0.
- MTHI/MTLO with start=1 and busy=0: hi (resp. lo) <= dInA at that edge. busy stays 0, no done.
- Ignored cases:
  - start while busy=1 is ignored (no queueing); the pipeline must stall.
  - Undefined op codes with start are ignored.
- flush=1 while busy: return to IDLE at that edge. busy=0 next cycle, no done, hi/lo keep their pre-op values.
- flush in IDLE has no effect.
- flush and start on the same edge in IDLE: flush wins; the op is not accepted.
- HI/LO change only on the FIX edge, an MT* edge, or reset. Partial results are never visible.

Decomposition:
- declarations.v (shared):
  - MD_op_mult=3'd0, MD_op_multu=3'd1, MD_op_div=3'd2, MD_op_divu=3'd3, MD_op_mthi=3'd4, MD_op_mtlo=3'd5;
  - MD_st_idle / MD_st_calc / MD_st_fix state encodings.
- Sub-module md_negate (parameter WIDTH): combinational conditional two's-complement, dOut = neg ? -dIn : dIn.
  - Instantiated for operand magnitude conversion and result fix-up.
  - The 2*WIDTH instance negates the product.
- All other logic lives in md_unit.

Test Plan (WIDTH=32):
- mult dInA=7, dInB=0xFFFFFFFD (-3) -> busy high exactly 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then mult same operands -> hi=0, lo=1.
- Divides:
  - div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/2 -> lo=3, hi=1.
  - div 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
- Corner divides:
  - divu 5/0 -> lo=0xFFFFFFFF, hi=5.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Latency unchanged (33 cycles).
- Abort/ignore:
  - mthi 0x1234 -> hi=0x1234 next cycle, busy stays 0.
  - Then multu 3x4 with flush at busy cycle 10 -> busy=0 next cycle, no done, hi=0x1234.
  - start(divu) pulsed during a busy op -> ignored; original result only.
- Reset mid-op: rst at busy cycle 5 -> next cycle busy=0, done=0, hi=lo=0.
  - Then mtlo 0xABCD -> lo=0xABCD.
  - Then start+flush on the same edge -> busy stays 0.
